// File: rtl/layer00_load_ctrl.sv
// Load sequencer for the layer00 conv engine: scatters an IFM stream over the input BRAM banks,
// holds the bias registers, then starts the engine and waits for its ready rising edge.
module layer00_load_ctrl #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_DEPTH = 128,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 128,
  parameter int BIAS_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_go,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic [NUM_BANKS-1:0] o_ena,
  output logic [NUM_BANKS-1:0] o_wea,
  output logic [ADDR_W-1:0]    o_addra,
  output logic [DATA_W-1:0]    o_dia,
  input  logic                 i_bias_we,
  input  logic [1:0]           i_bias_idx,
  input  logic [BIAS_W-1:0]    i_bias_data,
  output logic [BIAS_W-1:0]    o_bias0,
  output logic [BIAS_W-1:0]    o_bias1,
  output logic [BIAS_W-1:0]    o_bias2,
  output logic [BIAS_W-1:0]    o_bias3,
  output logic                 o_start,
  input  logic                 i_layer_ready
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int WORD_W = $clog2(BANK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_START, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [BANK_W-1:0]         bank_cnt;
  logic [WORD_W-1:0]         word_cnt;
  logic                      prev_rdy;
  logic                      beat, last_beat, rdy_rise;
  logic [3:0][BIAS_W-1:0]    bias_q;

  assign s_ready   = (state == S_LOAD);
  assign beat      = s_valid & s_ready;
  assign last_beat = beat && (bank_cnt == BANK_W'(NUM_BANKS-1)) && (word_cnt == WORD_W'(BANK_DEPTH-1));
  // Only a fresh rise counts, so a ready left high by a previous run cannot end this one.
  assign rdy_rise  = i_layer_ready & ~prev_rdy;
  assign o_busy    = (state != S_IDLE);
  assign o_start   = (state == S_START) || (state == S_WAIT);
  assign o_wea     = o_ena;
  assign o_bias0   = bias_q[0];
  assign o_bias1   = bias_q[1];
  assign o_bias2   = bias_q[2];
  assign o_bias3   = bias_q[3];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_go) state_nxt = S_LOAD;
      S_LOAD:  if (last_beat) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (rdy_rise) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bank_cnt <= '0;
      word_cnt <= '0;
      prev_rdy <= 1'b0;
      o_done   <= 1'b0;
      o_ena    <= '0;
      o_addra  <= '0;
      o_dia    <= '0;
      bias_q   <= '0;
    end else begin
      state    <= state_nxt;
      prev_rdy <= i_layer_ready;
      o_done   <= (state == S_WAIT) && rdy_rise;
      o_ena    <= beat ? ({{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_cnt) : '0;
      if (beat) begin
        o_addra <= ADDR_W'(word_cnt);
        o_dia   <= s_data;
        // word wrap carries straight into the bank counter
        {bank_cnt, word_cnt} <= {bank_cnt, word_cnt} + 1'b1;
      end
      if (state == S_IDLE && i_go) begin
        bank_cnt <= '0;
        word_cnt <= '0;
      end
      if (state == S_IDLE && i_bias_we) bias_q[i_bias_idx] <= i_bias_data;
    end
  end
endmodule
